mem_arbiter: RTL

- Shares the single DRAM request/response port among NUM_REQ requesters (tile loaders, writeback).
- Uses round-robin arbitration and a registered request slot toward the DRAM.
- The DRAM serves in order, so responses are routed back to their originator through an in-order source-tag FIFO.
- Caps outstanding transactions at MAX_OUTSTANDING.

---
 rtl/flexpipe_pkg.sv | 23 ++
 rtl/mem_arbiter_rr.sv | 51 +++++
 rtl/mem_arbiter.sv | 114 +++++++++++
 3 files changed

// File: rtl/flexpipe_pkg.sv
// Shared memory-interface types for the flexpipe datapath and the constants
// used to instantiate the DRAM arbiter.
package flexpipe_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [3:0]  id;
    logic [1:0]  epoch;
    logic        we;
  } mem_req_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  id;
    logic [1:0]  epoch;
    logic        last;
  } mem_resp_t;

  localparam int MEM_ARB_NUM_REQ         = 3;
  localparam int MEM_ARB_MAX_OUTSTANDING = 8;

endpackage

// File: rtl/mem_arbiter_rr.sv
// Round-robin picker: the first requester at or after the pointer wins, and
// the pointer moves just past the winner whenever the grant is consumed.
module rr_arbiter #(
  parameter int N  = 3,
  parameter int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  grant_onehot,
  output logic [IW-1:0] grant_idx
);

  logic [IW-1:0] ptr_r;

  // Combinational search starting at the pointer, wrapping modulo N
  always_comb begin
    int   idx_v;
    logic found_s;
    idx_v        = 0;
    found_s      = 1'b0;
    grant_onehot = '0;
    grant_idx    = '0;
    for (int k = 0; k < N; k++) begin
      idx_v = int'(ptr_r) + k;
      if (idx_v >= N) begin
        idx_v = idx_v - N;
      end else begin
        idx_v = idx_v;
      end
      if (!found_s && req[idx_v]) begin
        found_s             = 1'b1;
        grant_idx           = IW'(idx_v);
        grant_onehot[idx_v] = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Pointer register, advanced past the consumed grant
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_r <= '0;
    end else if (advance) begin
      ptr_r <= (grant_idx == IW'(N - 1)) ? '0 : grant_idx + IW'(1);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one in-order DRAM port among NUM_REQ requesters; an in-order tag FIFO
// routes each response back to the requester that issued it.
module mem_arbiter
  import flexpipe_pkg::*;
#(
  parameter int NUM_REQ         = MEM_ARB_NUM_REQ,
  parameter int MAX_OUTSTANDING = MEM_ARB_MAX_OUTSTANDING,
  parameter int SRC_W           = $clog2(NUM_REQ)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  mem_req_t                           req_in [NUM_REQ],
  input  logic [NUM_REQ-1:0]                 req_valid_in,
  output logic [NUM_REQ-1:0]                 req_ready_out,
  output mem_resp_t                          resp_out,
  output logic [NUM_REQ-1:0]                 resp_valid_out,
  output mem_req_t                           mem_req,
  output logic                               mem_req_valid,
  input  logic                               mem_req_ready,
  input  mem_resp_t                          mem_resp,
  input  logic                               mem_resp_valid,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
  output logic                               err_spurious
);

  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam int CW = PW + 1;
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  logic [NUM_REQ-1:0] grant_onehot_s;
  logic [SRC_W-1:0]   grant_idx_s;
  logic               slot_free_s;
  logic               can_accept_s;
  logic               accept_s;
  logic               fifo_empty_s;
  logic               pop_s;
  logic [SRC_W-1:0]   head_s;
  logic [PW-1:0]      wr_ptr_r;
  logic [PW-1:0]      rd_ptr_r;
  logic [SRC_W-1:0]   tag_mem_r [MAX_OUTSTANDING];

  rr_arbiter #(.N(NUM_REQ), .IW(SRC_W)) u_rr (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req_valid_in),
    .advance      (accept_s),
    .grant_onehot (grant_onehot_s),
    .grant_idx    (grant_idx_s)
  );

  assign slot_free_s   = !mem_req_valid || mem_req_ready;
  assign can_accept_s  = slot_free_s && (outstanding < CW'(MAX_OUTSTANDING));
  assign accept_s      = can_accept_s && (|grant_onehot_s);
  assign req_ready_out = can_accept_s ? grant_onehot_s : '0;

  // FIFO occupancy equals the outstanding count, so empty needs no extra state
  assign fifo_empty_s = (outstanding == '0);
  assign head_s       = tag_mem_r[rd_ptr_r];
  assign pop_s        = mem_resp_valid && !fifo_empty_s && mem_resp.last;

  // Request slot: payload is frozen while valid and not yet taken by the DRAM
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_req_valid <= 1'b0;
      mem_req       <= '0;
    end else if (accept_s) begin
      mem_req       <= req_in[grant_idx_s];
      mem_req_valid <= 1'b1;
    end else if (mem_req_ready) begin
      mem_req_valid <= 1'b0;
    end
  end

  // Tag storage; contents are meaningless outside the rd..wr window
  always_ff @(posedge clk) begin
    if (accept_s) begin
      tag_mem_r[wr_ptr_r] <= grant_idx_s;
    end
  end

  // Response routing, FIFO pointers and outstanding count
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      resp_valid_out <= '0;
      resp_out       <= '0;
      err_spurious   <= 1'b0;
      wr_ptr_r       <= '0;
      rd_ptr_r       <= '0;
      outstanding    <= '0;
    end else begin
      resp_valid_out <= '0;
      if (mem_resp_valid) begin
        if (!fifo_empty_s) begin
          resp_out       <= mem_resp;
          resp_valid_out <= ONE_HOT0 << head_s;
        end else begin
          err_spurious <= 1'b1;
        end
      end
      if (accept_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({accept_s, pop_s})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

endmodule
